// File: rtl/aer_fifo_out_if.sv
// AER output stage: buffers one-cycle spike events in a circular FIFO and
// drains them over a 4-phase active-low req/ack link.
// Ports: clk, reset (sync, active-high); ev_valid/ev_data event input;
//   aer_req/aer_data/aer_ack AER link; fifo_count occupancy;
//   drop_count saturating count of events lost to a full FIFO.
module aer_fifo_out_if #(
  parameter int DEPTH_LOG2 = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ev_valid,
  input  logic [DATA_WIDTH-1:0] ev_data,
  output logic                  aer_req,
  output logic [DATA_WIDTH-1:0] aer_data,
  input  logic                  aer_ack,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic [15:0]           drop_count
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] C_FULL =
    (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_REQ,
    S_RELEASE
  } state_t;

  state_t                  r_state;
  logic                    r_req;
  logic [DATA_WIDTH-1:0]   r_aer_data;
  logic                    r_ack_m;
  logic                    r_ack_s;
  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   r_wptr;
  logic [DEPTH_LOG2-1:0]   r_rptr;
  logic [DEPTH_LOG2:0]     r_count;
  logic [15:0]             r_drop;

  logic w_pop;
  logic w_full;
  logic w_push;
  logic w_drop;

  // A pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign w_pop  = (r_state == S_IDLE) && (r_count != '0) && r_ack_s;
  assign w_full = (r_count == C_FULL);
  assign w_push = ev_valid && (!w_full || w_pop);
  assign w_drop = ev_valid && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ack_m <= 1'b1;
      r_ack_s <= 1'b1;
    end else begin
      r_ack_m <= aer_ack;
      r_ack_s <= r_ack_m;
    end
  end

  // Storage needs no reset: clearing the pointers discards the contents.
  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      r_mem[r_wptr] <= ev_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_drop  <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_drop && (r_drop != 16'hFFFF)) begin
        r_drop <= r_drop + 1'b1;
      end
    end
  end

  // aer_req drops on the edge after REQ is entered, giving the
  // data one SETUP cycle plus one REQ cycle of setup before the request.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_req      <= 1'b1;
      r_aer_data <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_req <= 1'b1;
          if (w_pop) begin
            r_aer_data <= r_mem[r_rptr];
            r_state    <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_req   <= 1'b1;
          r_state <= S_REQ;
        end
        S_REQ: begin
          if (!r_ack_s) begin
            r_req   <= 1'b1;
            r_state <= S_RELEASE;
          end else begin
            r_req <= 1'b0;
          end
        end
        S_RELEASE: begin
          r_req <= 1'b1;
          if (r_ack_s) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_req   <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign aer_req    = r_req;
  assign aer_data   = r_aer_data;
  assign fifo_count = r_count;
  assign drop_count = r_drop;

endmodule

// File: tb/tb_aer_fifo_out_if.sv
// Bench for aer_fifo_out_if: queue scoreboard of expected AER addresses,
// a configurable downstream ack responder and directed plus random phases.
module tb_aer_fifo_out_if;

  localparam int DL = 4;
  localparam int DW = 16;

  bit            clk;
  logic          reset;
  logic          ev_valid;
  logic [DW-1:0] ev_data;
  logic          aer_req;
  logic [DW-1:0] aer_data;
  logic          aer_ack;
  logic [DL:0]   fifo_count;
  logic [15:0]   drop_count;

  aer_fifo_out_if #(
    .DEPTH_LOG2(DL),
    .DATA_WIDTH(DW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ev_valid  (ev_valid),
    .ev_data   (ev_data),
    .aer_req   (aer_req),
    .aer_data  (aer_data),
    .aer_ack   (aer_ack),
    .fifo_count(fifo_count),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int n_chk;
  int n_pass;
  int n_req;
  logic [DW-1:0] expq[$];

  // responder control: 0 = 4-phase responder, 1 = ack held high, 2 = ack held low
  int mode;
  int dly_cfg;
  bit rnd_en;

  task automatic chk(string nm, longint act, longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Downstream link model
  int cnt;
  int rthr;
  int thr;
  always @(negedge clk) begin
    if (mode == 1) begin
      aer_ack = 1'b1;
    end else if (mode == 2) begin
      aer_ack = 1'b0;
    end else begin
      thr = rnd_en ? rthr : dly_cfg;
      if (aer_ack !== aer_req) begin
        if (cnt >= thr) begin
          aer_ack = aer_req;
          cnt = 0;
          rthr = $urandom_range(0, 8);
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor: each request start is matched against the scoreboard head
  logic          prev_req;
  logic [DW-1:0] held;
  logic [DW-1:0] e;
  always @(negedge clk) begin
    if (prev_req === 1'b1 && aer_req === 1'b0) begin
      n_req++;
      held = aer_data;
      if (expq.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_req: got data %0h with no event expected",
                 aer_data);
      end else begin
        e = expq.pop_front();
        chk("aer_data", aer_data, e);
      end
    end else if (prev_req === 1'b0 && aer_req === 1'b0) begin
      chk("aer_data_stable", aer_data, held);
    end
    prev_req = aer_req;
  end

  task automatic push_ev(logic [DW-1:0] d, bit expect_it);
    ev_data  = d;
    ev_valid = 1'b1;
    if (expect_it) expq.push_back(d);
    step();
    ev_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (expq.size() == 0 && fifo_count == 0 &&
          aer_req === 1'b1 && aer_ack === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    chk("drain_done", ok, 1);
    repeat (4) step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int base;
  int k;
  int peak;
  logic [DW-1:0] d;

  initial begin
    mode     = 1;
    reset    = 1'b1;
    ev_valid = 1'b0;
    ev_data  = '0;
    repeat (3) step();
    chk("rst_req", aer_req, 1);
    chk("rst_data", aer_data, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_drop", drop_count, 0);
    reset   = 1'b0;
    mode    = 0;
    dly_cfg = 0;
    repeat (3) step();

    // Single event, immediate responder, request at edge N+3
    base = n_req;
    ev_data  = 16'h1234;
    ev_valid = 1'b1;
    expq.push_back(16'h1234);
    step();
    ev_valid = 1'b0;
    k = 0;
    while (aer_req === 1'b1 && k < 20) begin
      step();
      k++;
    end
    chk("latency", k, 3);
    wait_idle();
    chk("single_reqs", n_req - base, 1);
    chk("single_count", fifo_count, 0);

    // Burst of 5 with slow ack
    dly_cfg = 10;
    base = n_req;
    peak = 0;
    for (int i = 0; i < 5; i++) begin
      d = DW'($urandom);
      ev_data  = d;
      ev_valid = 1'b1;
      expq.push_back(d);
      step();
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
    end
    ev_valid = 1'b0;
    repeat (10) begin
      step();
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
    end
    wait_idle();
    chk("burst_reqs", n_req - base, 5);
    chk("burst_drop", drop_count, 0);
    chk("burst_peak_4_or_5", (peak == 4 || peak == 5), 1);

    // Overflow with stalled downstream: 1 in flight + 16 stored, 3 lost
    mode = 1;
    base = n_req;
    for (int i = 0; i < 20; i++) begin
      d = DW'($urandom);
      ev_data  = d;
      ev_valid = 1'b1;
      if (i < 17) expq.push_back(d);
      step();
    end
    ev_valid = 1'b0;
    step();
    chk("ovf_count", fifo_count, 16);
    chk("ovf_drop", drop_count, 3);
    mode    = 0;
    dly_cfg = 2;
    wait_idle();
    chk("ovf_reqs", n_req - base, 17);
    chk("ovf_drop_after", drop_count, 3);

    // Stale ack across reset, then full FIFO with simultaneous pop
    mode = 2;
    repeat (2) step();
    reset = 1'b1;
    repeat (2) step();
    chk("stale_rst_drop", drop_count, 0);
    reset = 1'b0;
    repeat (3) step();
    base = n_req;
    for (int i = 0; i < 17; i++) begin
      push_ev(DW'($urandom), (i < 16));
    end
    repeat (5) step();
    chk("stale_count", fifo_count, 16);
    chk("stale_drop", drop_count, 1);
    chk("stale_no_req", n_req - base, 0);
    chk("stale_req_high", aer_req, 1);
    mode = 1;
    step();
    step();
    push_ev(16'hA5C3, 1'b1);
    chk("fullpop_count", fifo_count, 16);
    chk("fullpop_drop", drop_count, 1);
    mode    = 0;
    dly_cfg = 1;
    wait_idle();
    chk("fullpop_reqs", n_req - base, 17);

    // Random traffic, random ack delays, never enough backlog to drop
    rnd_en = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if (expq.size() < 10 && $urandom_range(0, 2) == 0) begin
        d = DW'($urandom);
        ev_data  = d;
        ev_valid = 1'b1;
        expq.push_back(d);
      end else begin
        ev_valid = 1'b0;
      end
      step();
    end
    ev_valid = 1'b0;
    wait_idle();
    rnd_en = 1'b0;
    chk("rand_drop", drop_count, 1);
    chk("rand_count", fifo_count, 0);

    // Reset while the request is asserted
    mode = 1;
    push_ev(16'hBEEF, 1'b1);
    k = 0;
    while (aer_req === 1'b1 && k < 20) begin
      step();
      k++;
    end
    chk("mid_req_low", aer_req, 0);
    push_ev(16'h0001, 1'b1);
    push_ev(16'h0002, 1'b1);
    reset = 1'b1;
    step();
    chk("mid_rst_req", aer_req, 1);
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_drop", drop_count, 0);
    reset = 1'b0;
    expq.delete();
    base = n_req;
    mode = 0;
    repeat (30) step();
    chk("mid_no_req", n_req - base, 0);
    chk("mid_req_high", aer_req, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
